// File: rtl/dm_responder_if.sv
// Request/response channel between the CPU memory-access stage and dm_responder.
// The master drives requests and accepts responses; the slave does the reverse.
interface dm_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_responder.sv
// Word data-memory responder: the response is visible WAIT_CYCLES+1 cycles after the request cycle.
// One access in flight at a time; a stalled response holds its outputs and the write commits only once.
module dm_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  dm_responder_if.slave   bus,
  output logic            busy
);
  localparam int IDXW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] mem_d [DEPTH_WORDS];

  logic            go_resp;
  logic            acc_wr;
  logic [31:0]     acc_addr;
  logic [31:0]     acc_wdata;
  logic [32:0]     acc_off;
  logic            acc_err;
  logic [IDXW-1:0] acc_idx;

  // With no wait states the access happens on the acceptance edge, so use the live request.
  always_comb begin
    acc_wr    = (state_q == IDLE) ? bus.req_write : wr_q;
    acc_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
    acc_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
    acc_off   = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
    acc_idx   = acc_off[IDXW+1:2];
    acc_err   = (|acc_off[1:0]) | acc_off[32] | (|acc_off[31:IDXW+2]);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_d   = mem_q;
    go_resp = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          wr_d    = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (WAIT_CYCLES == 0) begin
            go_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) go_resp = 1'b1;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (go_resp) begin
      state_d = RESP;
      err_d   = acc_err;
      rdata_d = 32'h0;
      if (!acc_err) begin
        if (acc_wr) mem_d[acc_idx] = acc_wdata;
        else        rdata_d        = mem_q[acc_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance
// share one stimulus path; sel chooses which one receives requests and is observed.
module tb_dm_responder;
  logic clk;
  logic rst_n;
  logic sel;
  logic v, wr, rr;
  logic [31:0] a, d;
  logic busy2, busy0;
  logic o_rdy, o_vld, o_err, o_busy;
  logic [31:0] o_rd;
  int total;
  int bad;

  dm_responder_if bus2();
  dm_responder_if bus0();

  assign bus2.req_valid  = v & ~sel;
  assign bus2.req_write  = wr;
  assign bus2.req_addr   = a;
  assign bus2.req_wdata  = d;
  assign bus2.resp_ready = rr;
  assign bus0.req_valid  = v & sel;
  assign bus0.req_write  = wr;
  assign bus0.req_addr   = a;
  assign bus0.req_wdata  = d;
  assign bus0.resp_ready = rr;

  assign o_rdy  = sel ? bus0.req_ready  : bus2.req_ready;
  assign o_vld  = sel ? bus0.resp_valid : bus2.resp_valid;
  assign o_rd   = sel ? bus0.resp_rdata : bus2.resp_rdata;
  assign o_err  = sel ? bus0.resp_err   : bus2.resp_err;
  assign o_busy = sel ? busy0           : busy2;

  dm_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .busy(busy2)
  );
  dm_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts and ends at a falling edge; resp_ready must already be high.
  task automatic xfer(input logic w, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input string tag);
    int lat;
    int want_lat;
    want_lat = sel ? 1 : 3;
    wr = w; a = addr; d = wd; v = 1'b1;
    chk({tag, ":acc_rdy"}, o_rdy, 1);
    @(posedge clk); #1 v = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!o_vld) chk({tag, ":wait_rdy"}, o_rdy, 0);
    end while (!o_vld && lat < 20);
    chk({tag, ":latency"}, 32'(lat), 32'(want_lat));
    chk({tag, ":rdata"}, o_rd, exp_rd);
    chk({tag, ":err"}, o_err, exp_err);
    chk({tag, ":resp_rdy"}, o_rdy, 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ":after_vld"}, o_vld, 0);
    chk({tag, ":after_rdy"}, o_rdy, 1);
  endtask

  initial begin
    logic [31:0] bb_dat [4];
    int n;
    bb_dat = '{32'h0101_0101, 32'h2020_2020, 32'h0303_0303, 32'h4040_4040};
    total = 0; bad = 0;
    rst_n = 1'b0; sel = 1'b0; v = 1'b0; wr = 1'b0; rr = 1'b1; a = 32'h0; d = 32'h0;

    @(negedge clk);
    chk("rst:req_ready", o_rdy, 1);
    chk("rst:resp_valid", o_vld, 0);
    chk("rst:rdata", o_rd, 0);
    chk("rst:err", o_err, 0);
    chk("rst:busy", o_busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    xfer(1'b0, 32'h08, 32'h0, 32'h0, 1'b0, "rd08");
    xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, "wr10");
    xfer(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, "rd10");
    xfer(1'b1, 32'h12, 32'hBAD0_BAD0, 32'h0, 1'b1, "wr12_misal");
    xfer(1'b1, 32'h100, 32'hBAD1_BAD1, 32'h0, 1'b1, "wr100_oor");
    xfer(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, "rd10_again");
    xfer(1'b1, 32'hFC, 32'hCAFE_F00D, 32'h0, 1'b0, "wrFC_last");
    xfer(1'b0, 32'hFC, 32'h0, 32'hCAFE_F00D, 1'b0, "rdFC_last");
    xfer(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, "rd00_alias");
    xfer(1'b0, 32'h100, 32'h0, 32'h0, 1'b1, "rd100_oor");

    // Stalled read: outputs frozen, stray requests ignored.
    rr = 1'b0; wr = 1'b0; a = 32'h10; v = 1'b1;
    @(posedge clk); #1 v = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!o_vld && n < 20);
    chk("stall:latency", 32'(n), 32'd3);
    for (int i = 0; i < 10; i++) begin
      chk("stall:vld", o_vld, 1);
      chk("stall:rdata", o_rd, 32'hDEAD_BEEF);
      chk("stall:busy", o_busy, 1);
      chk("stall:rdy", o_rdy, 0);
      wr = 1'b1; a = 32'h20; d = 32'hFFFF_FFFF; v = ~v;
      @(negedge clk);
    end
    v = 1'b0; rr = 1'b1;
    chk("stall:last_vld", o_vld, 1);
    @(posedge clk);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_vld) n++;
    end
    chk("stall:extra_resp", 32'(n), 32'd0);
    xfer(1'b0, 32'h20, 32'h0, 32'h0, 1'b0, "stall:rd20");

    // Reset during WAIT discards the pending write and clears memory.
    wr = 1'b1; a = 32'h20; d = 32'h1234_5678; v = 1'b1;
    chk("rstw:acc_rdy", o_rdy, 1);
    @(posedge clk); #1 v = 1'b0;
    @(negedge clk);
    chk("rstw:busy_wait", o_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rstw:busy", o_busy, 0);
    chk("rstw:rdy", o_rdy, 1);
    chk("rstw:vld", o_vld, 0);
    chk("rstw:rdata", o_rd, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    xfer(1'b0, 32'h20, 32'h0, 32'h0, 1'b0, "rstw:rd20");
    xfer(1'b0, 32'h10, 32'h0, 32'h0, 1'b0, "rstw:rd10_cleared");

    // Zero-wait instance: preload, then four back-to-back reads.
    sel = 1'b1;
    for (int i = 0; i < 4; i++)
      xfer(1'b1, 32'(i * 4), bb_dat[i], 32'h0, 1'b0, $sformatf("w0:wr%0d", i));
    for (int i = 0; i < 4; i++) begin
      wr = 1'b0; a = 32'(i * 4); v = 1'b1;
      chk($sformatf("b2b%0d:acc_rdy", i), o_rdy, 1);
      chk($sformatf("b2b%0d:idle_vld", i), o_vld, 0);
      @(posedge clk); #1;
      if (i == 3) v = 1'b0;
      @(negedge clk);
      chk($sformatf("b2b%0d:vld", i), o_vld, 1);
      chk($sformatf("b2b%0d:rdata", i), o_rd, bb_dat[i]);
      @(posedge clk);
      @(negedge clk);
    end
    chk("b2b:end_vld", o_vld, 0);
    chk("b2b:end_rdy", o_rdy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end
endmodule
